uart_out_arbiter: RTL and testbench

Shares the simulation top's single UART output byte channel between N_REQ requesters (harts, devices, DPI shims) and sequences end-of-simulation. Round-robin arbitration with line atomicity: a requester holds the channel from its first byte until its newline, so console lines never interleave. A finish byte (bit 7 set) from any requester drives a fixed sequence on the same outputs the bench consumes: one-cycle perf-dump pulse, drain window, sticky done flag.

---
 rtl/uart_out_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_out_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_out_arbiter.sv
// Round-robin, line-atomic arbiter for the simulation console byte channel,
// plus the finish sequence (perf dump pulse, drain window, sticky done).
module uart_out_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned LINE_TIMEOUT = 256,
    parameter int unsigned DRAIN_CYCLES = 16,
    localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_ch,
    output logic [N_REQ-1:0]   req_ready,
    output logic               uart_out_valid,
    output logic [7:0]         uart_out_ch,
    output logic               perf_dump,
    output logic               sim_done,
    output logic [SW-1:0]      finish_src,
    output logic [SW:0]        lock_owner
);

    localparam int unsigned TW = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(LINE_TIMEOUT - 1);
    localparam logic [DW-1:0] DMAX = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOCKED, DUMP, DRAIN, DONE} state_t;

    state_t        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] owner;
    logic [TW-1:0] timer;
    logic [DW-1:0] drain_cnt;

    logic          found;
    logic [SW-1:0] win;
    logic [SW-1:0] cand;
    logic [SW-1:0] sel;
    logic          accept;
    logic [7:0]    byte_in;
    int unsigned   idx;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        return (32'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = SW'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel       = '0;
        if (reset) begin
            if (state == IDLE && found) begin
                req_ready[win] = 1'b1;
                sel            = win;
            end else if (state == LOCKED && req_valid[owner]) begin
                req_ready[owner] = 1'b1;
                sel              = owner;
            end
        end
    end

    assign accept  = |req_ready;
    assign byte_in = req_ch[{sel, 3'b000} +: 8];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            timer          <= '0;
            drain_cnt      <= '0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= '0;
            perf_dump      <= 1'b0;
            sim_done       <= 1'b0;
            finish_src     <= '0;
            lock_owner     <= '0;
        end else begin
            uart_out_valid <= accept;
            if (accept) uart_out_ch <= byte_in;
            perf_dump <= (state == DUMP);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (byte_in[7]) begin
                            state      <= DUMP;
                            finish_src <= sel;
                        end else if (byte_in == 8'h0A) begin
                            rr_ptr <= next_idx(sel);
                        end else begin
                            state      <= LOCKED;
                            owner      <= sel;
                            timer      <= '0;
                            lock_owner <= {1'b1, sel};
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (byte_in[7]) begin
                            state      <= DUMP;
                            finish_src <= owner;
                            lock_owner <= '0;
                        end else if (byte_in == 8'h0A) begin
                            state      <= IDLE;
                            rr_ptr     <= next_idx(owner);
                            lock_owner <= '0;
                        end else begin
                            timer <= '0;
                        end
                    end else if (timer == TMAX) begin
                        // Stalled line: drop the lock so other requesters can proceed.
                        state      <= IDLE;
                        rr_ptr     <= next_idx(owner);
                        lock_owner <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DUMP: begin
                    state     <= DRAIN;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (drain_cnt == DMAX) begin
                        state    <= DONE;
                        sim_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    sim_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed bench for uart_out_arbiter: line atomicity, round-robin, timeout,
// finish sequence and asynchronous reset.
module tb_uart_out_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_ch;
    logic [3:0]  req_ready;
    logic        uart_out_valid;
    logic [7:0]  uart_out_ch;
    logic        perf_dump;
    logic        sim_done;
    logic [1:0]  finish_src;
    logic [2:0]  lock_owner;

    int n_cmp = 0;
    int n_err = 0;

    uart_out_arbiter #(
        .N_REQ(4),
        .LINE_TIMEOUT(8),
        .DRAIN_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ch(req_ch),
        .req_ready(req_ready),
        .uart_out_valid(uart_out_valid),
        .uart_out_ch(uart_out_ch),
        .perf_dump(perf_dump),
        .sim_done(sim_done),
        .finish_src(finish_src),
        .lock_owner(lock_owner)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
        req_valid = v;
        req_ch    = {c3, c2, c1, c0};
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_ch    = '0;
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] ch);
        check({tag, "_valid"}, uart_out_valid, 1'b1);
        check({tag, "_ch"}, uart_out_ch, ch);
    endtask

    initial begin
        // Reset state, with requests already pending
        reset = 1'b0;
        drive(4'b1111, 8'h41, 8'h42, 8'h43, 8'h44);
        #2;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_valid", uart_out_valid, 1'b0);
        check("rst_ch", uart_out_ch, 8'h00);
        check("rst_perf", perf_dump, 1'b0);
        check("rst_done", sim_done, 1'b0);
        check("rst_src", finish_src, 2'd0);
        check("rst_lock", lock_owner, 3'd0);
        do_reset();

        // Requester 0 sends "hi\n"
        drive(4'b0001, 8'h68, 8'h00, 8'h00, 8'h00);
        check("hi_rdy0", req_ready, 4'b0001);
        step();
        expect_byte("hi_h", 8'h68);
        check("hi_lock_h", lock_owner, 3'h4);
        drive(4'b0001, 8'h69, 8'h00, 8'h00, 8'h00);
        check("hi_rdy1", req_ready, 4'b0001);
        step();
        expect_byte("hi_i", 8'h69);
        check("hi_lock_i", lock_owner, 3'h4);
        drive(4'b0001, 8'h0A, 8'h00, 8'h00, 8'h00);
        step();
        expect_byte("hi_nl", 8'h0A);
        check("hi_lock_nl", lock_owner, 3'h0);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check("hi_idle_valid", uart_out_valid, 1'b0);

        // Requesters 0 and 1 both send "ab\n"; lines must not interleave
        do_reset();
        drive(4'b0011, 8'h61, 8'h61, 8'h00, 8'h00);
        check("ab_rdy_a0", req_ready, 4'b0001);
        step();
        expect_byte("ab0_a", 8'h61);
        check("ab0_lock", lock_owner, 3'h4);
        drive(4'b0011, 8'h62, 8'h61, 8'h00, 8'h00);
        check("ab_rdy_b0", req_ready, 4'b0001);
        step();
        expect_byte("ab0_b", 8'h62);
        drive(4'b0011, 8'h0A, 8'h61, 8'h00, 8'h00);
        check("ab_rdy_nl0", req_ready, 4'b0001);
        step();
        expect_byte("ab0_nl", 8'h0A);
        check("ab0_unlock", lock_owner, 3'h0);
        drive(4'b0010, 8'h00, 8'h61, 8'h00, 8'h00);
        check("ab_rdy_a1", req_ready, 4'b0010);
        step();
        expect_byte("ab1_a", 8'h61);
        check("ab1_lock", lock_owner, 3'h5);
        drive(4'b0010, 8'h00, 8'h62, 8'h00, 8'h00);
        step();
        expect_byte("ab1_b", 8'h62);
        drive(4'b0010, 8'h00, 8'h0A, 8'h00, 8'h00);
        step();
        expect_byte("ab1_nl", 8'h0A);
        check("ab1_unlock", lock_owner, 3'h0);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // Requester 2 sends "x" then stalls; requester 3 waits for the timeout
        drive(4'b0100, 8'h00, 8'h00, 8'h78, 8'h00);
        check("to_rdy2", req_ready, 4'b0100);
        step();
        expect_byte("to_x", 8'h78);
        check("to_lock", lock_owner, 3'h6);
        drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h79);
        check("to_stall", req_ready, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            step();
            check("to_held", lock_owner, 3'h6);
            check("to_stall_ready", req_ready, 4'b0000);
            check("to_no_byte", uart_out_valid, 1'b0);
        end
        step();
        check("to_released", lock_owner, 3'h0);
        check("to_rdy3", req_ready, 4'b1000);
        step();
        expect_byte("to_y", 8'h79);
        check("to_lock3", lock_owner, 3'h7);
        drive(4'b1000, 8'h00, 8'h00, 8'h00, 8'h0A);
        step();
        expect_byte("to_nl3", 8'h0A);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // Finish from requester 1 while requester 2 offers a newline
        drive(4'b0110, 8'h00, 8'h80, 8'h0A, 8'h00);
        check("fin_rdy", req_ready, 4'b0010);
        step();
        expect_byte("fin_byte", 8'h80);
        check("fin_src", finish_src, 2'd1);
        check("fin_perf_t1", perf_dump, 1'b0);
        check("fin_rdy_dump", req_ready, 4'b0000);
        step();
        check("fin_perf_t2", perf_dump, 1'b1);
        check("fin_dropped", uart_out_valid, 1'b0);
        check("fin_done_t2", sim_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fin_perf_low", perf_dump, 1'b0);
            check("fin_not_done", sim_done, 1'b0);
            check("fin_rdy_drain", req_ready, 4'b0000);
        end
        step();
        check("fin_done_t6", sim_done, 1'b1);
        step();
        step();
        check("fin_done_sticky", sim_done, 1'b1);
        check("fin_src_hold", finish_src, 2'd1);
        check("fin_rdy_done", req_ready, 4'b0000);

        // Reset asserted during the drain window
        do_reset();
        drive(4'b0010, 8'h00, 8'h80, 8'h00, 8'h00);
        step();
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check("rd_perf_before", perf_dump, 1'b1);
        reset = 1'b0;
        #1;
        check("rd_perf", perf_dump, 1'b0);
        check("rd_done", sim_done, 1'b0);
        check("rd_valid", uart_out_valid, 1'b0);
        check("rd_src", finish_src, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        drive(4'b0001, 8'h6F, 8'h00, 8'h00, 8'h00);
        check("rd_rdy0", req_ready, 4'b0001);
        step();
        expect_byte("rd_o", 8'h6F);
        check("rd_lock", lock_owner, 3'h4);
        drive(4'b0001, 8'h0A, 8'h00, 8'h00, 8'h00);
        step();
        expect_byte("rd_nl", 8'h0A);
        drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

        // Finish byte from the owner in the middle of a line
        drive(4'b0100, 8'h00, 8'h00, 8'h6B, 8'h00);
        check("ml_rdy2", req_ready, 4'b0100);
        step();
        expect_byte("ml_k", 8'h6B);
        check("ml_lock", lock_owner, 3'h6);
        drive(4'b0110, 8'h00, 8'h7A, 8'h8A, 8'h00);
        check("ml_rdy_fin", req_ready, 4'b0100);
        step();
        expect_byte("ml_fin", 8'h8A);
        check("ml_src", finish_src, 2'd2);
        check("ml_rdy_dump", req_ready, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("ml_no_byte", uart_out_valid, 1'b0);
            check("ml_not_done", sim_done, 1'b0);
        end
        step();
        check("ml_done", sim_done, 1'b1);
        check("ml_no_byte_end", uart_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
